// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
//   Shared definitions for the 4x4 matrix keypad scanner:
//     - state_t            : scanner FSM states
//     - KEY_TABLE          : hex code for each key, indexed by {row, column}
//     - DEFAULT_SCAN_DIV   : default clk cycles per column dwell
//     - DEFAULT_DB_COUNT   : default dwell ticks needed to accept press/release
//     - lowest_low_row()   : priority pick of the lowest active-low row
// ---------------------------------------------------------------------------
package keypad_pkg;

  localparam int DEFAULT_SCAN_DIV = 1000;
  localparam int DEFAULT_DB_COUNT = 4;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // Index is {row[1:0], column[1:0]}. Row 3 carries '*' as E and '#' as F.
  localparam logic [3:0] KEY_TABLE [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // Rows are active-low; when several keys in one column are down the
  // lowest-numbered row wins.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// ---------------------------------------------------------------------------
// keypad_tick_gen
//   Free-running divider producing a one-cycle scan tick every SCAN_DIV clocks.
//   The counter wraps SCAN_DIV-1 -> 0 and tick is high while it sits at
//   SCAN_DIV-1, so the first tick after reset lands on the SCAN_DIV-th edge.
// Ports:
//   clk   in  system clock
//   rst_n in  synchronous active-low reset
//   tick  out one-cycle pulse, once per SCAN_DIV cycles
// ---------------------------------------------------------------------------
module keypad_tick_gen
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = DEFAULT_SCAN_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n)             count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + CW'(1);
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one column per dwell period,
//   debounces press and release over DB_COUNT dwell ticks, and presents the
//   accepted key as a hex code with a valid/acknowledge handshake.
// Ports:
//   clk         in  system clock
//   rst_n       in  synchronous active-low reset
//   row_i[3:0]  in  keypad rows, active-low, asynchronous to clk
//   col_o[3:0]  out column drive, exactly one bit low
//   key_o[3:0]  out hex code of the last accepted key
//   key_valid_o out key_o holds an unacknowledged key
//   key_ack_i   in  consumer acknowledge (pulse or level)
//   overrun_o   out one-cycle pulse: new key accepted over an unacked one
// ---------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = DEFAULT_SCAN_DIV,
  parameter int DB_COUNT = DEFAULT_DB_COUNT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] key_o,
  output logic       key_valid_o,
  input  logic       key_ack_i,
  output logic       overrun_o
);

  localparam int DBW = $clog2(DB_COUNT + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_COUNT - 1);

  logic [3:0]     row_meta;
  logic [3:0]     rs;
  logic           tick;

  state_t         state, state_next;
  logic [1:0]     col_idx, col_next;
  logic [1:0]     row_idx, row_next;
  logic [DBW-1:0] count, count_next;
  logic           accept;
  logic [3:0]     accept_code;

  keypad_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Rows come straight from the keypad; resetting to all-high means
  // "no key" so nothing is detected until real samples arrive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      rs       <= 4'hF;
    end else begin
      row_meta <= row_i;
      rs       <= row_meta;
    end
  end

  // State register together with the column/row/count it steers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_SCAN;
      col_idx <= 2'd0;
      row_idx <= 2'd0;
      count   <= '0;
    end else begin
      state   <= state_next;
      col_idx <= col_next;
      row_idx <= row_next;
      count   <= count_next;
    end
  end

  // Next-state logic. Everything only moves on a scan tick; the column is
  // frozen from detection until the release has been debounced, so the key
  // being watched stays driven the whole time.
  always_comb begin
    state_next = state;
    col_next   = col_idx;
    row_next   = row_idx;
    count_next = count;
    accept     = 1'b0;
    if (tick) begin
      case (state)
        ST_SCAN: begin
          if (rs == 4'hF) begin
            col_next = col_idx + 2'd1;
          end else begin
            row_next   = lowest_low_row(rs);
            count_next = DBW'(1);
            if (DB_COUNT == 1) begin
              accept     = 1'b1;
              state_next = ST_HELD;
            end else begin
              state_next = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (!rs[row_idx]) begin
            count_next = count + DBW'(1);
            if (count == DB_LAST) begin
              accept     = 1'b1;
              state_next = ST_HELD;
            end
          end else begin
            state_next = ST_SCAN;
            col_next   = col_idx + 2'd1;
          end
        end
        ST_HELD: begin
          if (rs == 4'hF) begin
            count_next = DBW'(1);
            if (DB_COUNT == 1) begin
              state_next = ST_SCAN;
              col_next   = col_idx + 2'd1;
            end else begin
              state_next = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (rs == 4'hF) begin
            count_next = count + DBW'(1);
            if (count == DB_LAST) begin
              state_next = ST_SCAN;
              col_next   = col_idx + 2'd1;
            end
          end else begin
            state_next = ST_HELD;
          end
        end
        default: begin
          state_next = ST_SCAN;
        end
      endcase
    end
  end

  // Output logic: a single low bit on the current column.
  always_comb begin
    col_o       = ~(4'b0001 << col_idx);
    accept_code = KEY_TABLE[{row_next, col_idx}];
  end

  // Key handshake. An accept always wins over an ack in the same cycle, so
  // the fresh key is never lost; overrun only flags a key that displaced an
  // unacknowledged one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_o       <= 4'h0;
      key_valid_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      overrun_o <= accept & key_valid_o & ~key_ack_i;
      if (accept) begin
        key_o       <= accept_code;
        key_valid_o <= 1'b1;
      end else if (key_ack_i) begin
        key_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
//   Self-checking bench for keypad_scanner with SCAN_DIV = 4, DB_COUNT = 2.
//   A single-key keypad is emulated from col_o; a tick-level reference model
//   tracks column, debounce progress and the valid/ack handshake.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DB_COUNT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic [3:0] key_o;
  logic       key_valid_o;
  logic       key_ack_i = 1'b0;
  logic       overrun_o;

  int tests_run = 0;
  int tests_failed = 0;

  // Emulated keypad: at most one key down at (k_row, k_col).
  logic k_down = 1'b0;
  int   k_row = 0;
  int   k_col = 0;

  // Reference model state.
  int         edges;
  int         m_col;
  int         m_target;
  int         m_run;
  int         m_rel;
  bit         m_accepted;
  logic [3:0] m_key;
  logic       m_valid;
  logic       m_overrun;

  int keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

  keypad_scanner #(
    .SCAN_DIV (SCAN_DIV),
    .DB_COUNT (DB_COUNT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_i       (row_i),
    .col_o       (col_o),
    .key_o       (key_o),
    .key_valid_o (key_valid_o),
    .key_ack_i   (key_ack_i),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_i = 4'hF;
    if (k_down && col_o[k_col] == 1'b0) row_i[k_row] = 1'b0;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the bench finished");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [3:0] exp_col();
    return ~(4'b0001 << m_col);
  endfunction

  task automatic model_reset();
    edges      = 0;
    m_col      = 0;
    m_target   = -1;
    m_run      = 0;
    m_rel      = 0;
    m_accepted = 0;
    m_key      = 4'h0;
    m_valid    = 1'b0;
    m_overrun  = 1'b0;
  endtask

  // Advance one clock and update the model for that edge. Key changes are
  // made only early in a dwell, so at each tick the synchronized rows reflect
  // the current key and column.
  task automatic step();
    logic ack_s, rst_s;
    bit   acc;
    int   vis_row;
    logic [3:0] code;
    ack_s = key_ack_i;
    rst_s = rst_n;
    acc   = 0;
    code  = 4'h0;
    @(posedge clk);
    #1;
    if (!rst_s) begin
      model_reset();
    end else begin
      edges++;
      if (edges % SCAN_DIV == 0) begin
        vis_row = (k_down && k_col == m_col) ? k_row : -1;
        if (m_target < 0) begin
          if (vis_row >= 0) begin
            m_target = vis_row;
            m_run    = 1;
            if (m_run == DB_COUNT) acc = 1;
          end else begin
            m_col = (m_col + 1) % 4;
          end
        end else if (!m_accepted) begin
          if (vis_row == m_target) begin
            m_run++;
            if (m_run == DB_COUNT) acc = 1;
          end else begin
            m_target = -1;
            m_col    = (m_col + 1) % 4;
          end
        end else begin
          if (vis_row >= 0) begin
            m_rel = 0;
          end else begin
            m_rel++;
            if (m_rel == DB_COUNT) begin
              m_target   = -1;
              m_accepted = 0;
              m_col      = (m_col + 1) % 4;
            end
          end
        end
        if (acc) begin
          m_accepted = 1;
          m_rel      = 0;
          code       = 4'(keymap[m_target][m_col]);
        end
      end
      if (acc) begin
        m_overrun = m_valid && !ack_s;
        m_valid   = 1'b1;
        m_key     = code;
      end else begin
        m_overrun = 1'b0;
        if (ack_s) m_valid = 1'b0;
      end
    end
  endtask

  // Step until a tick boundary with column c driven and no key latched.
  task automatic wait_for_idle_col(input int c);
    int n;
    n = 0;
    while (!(edges % SCAN_DIV == 0 && m_col == c && m_target < 0) && n < 80) begin
      step();
      n++;
    end
    if (n >= 80) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL wait_col timeout: col_o=%b after %0d cycles, wanted column %0d", col_o, n, c);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step();
    tests_run++;
    if (col_o !== 4'b1110) begin tests_failed++; $display("[TB] FAIL reset_col got %b expected 1110", col_o); end
    tests_run++;
    if (key_o !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_key got %h expected 0", key_o); end
    tests_run++;
    if (key_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid got %b expected 0", key_valid_o); end
    tests_run++;
    if (overrun_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_overrun got %b expected 0", overrun_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    logic [3:0] seq [5];
    seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    for (int c = 0; c < 20; c++) begin
      tests_run++;
      if (col_o !== seq[c / 4]) begin
        tests_failed++;
        $display("[TB] FAIL idle_col cycle %0d got %b expected %b", c, col_o, seq[c / 4]);
      end
      step();
    end
  endtask

  task automatic test_press_key6();
    wait_for_idle_col(2);
    k_down = 1'b1; k_row = 1; k_col = 2;
    for (int i = 0; i < 12; i++) begin
      step();
      tests_run++;
      if ({col_o, key_o, key_valid_o, overrun_o} !== {exp_col(), m_key, m_valid, m_overrun}) begin
        tests_failed++;
        $display("[TB] FAIL press6_cycle got col/key/v/ovr %b/%h/%b/%b expected %b/%h/%b/%b",
                 col_o, key_o, key_valid_o, overrun_o, exp_col(), m_key, m_valid, m_overrun);
      end
    end
    tests_run++;
    if (key_o !== 4'h6) begin tests_failed++; $display("[TB] FAIL press6_key got %h expected 6", key_o); end
    tests_run++;
    if (key_valid_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL press6_valid got %b expected 1", key_valid_o); end
    tests_run++;
    if (col_o !== 4'b1011) begin tests_failed++; $display("[TB] FAIL press6_col_frozen got %b expected 1011", col_o); end
    key_ack_i = 1'b1;
    step();
    key_ack_i = 1'b0;
    tests_run++;
    if (key_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL press6_ack_valid got %b expected 0", key_valid_o); end
    tests_run++;
    if (key_o !== 4'h6) begin tests_failed++; $display("[TB] FAIL press6_key_hold got %h expected 6", key_o); end
    k_down = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      tests_run++;
      if ({col_o, key_o, key_valid_o, overrun_o} !== {exp_col(), m_key, m_valid, m_overrun}) begin
        tests_failed++;
        $display("[TB] FAIL press6_release got col/key/v/ovr %b/%h/%b/%b expected %b/%h/%b/%b",
                 col_o, key_o, key_valid_o, overrun_o, exp_col(), m_key, m_valid, m_overrun);
      end
    end
  endtask

  task automatic test_bounce();
    wait_for_idle_col(2);
    k_down = 1'b1; k_row = 2; k_col = 2;
    for (int i = 0; i < 4; i++) step();
    k_down = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if ({col_o, key_valid_o, overrun_o} !== {exp_col(), m_valid, m_overrun}) begin
        tests_failed++;
        $display("[TB] FAIL bounce_cycle got col/v/ovr %b/%b/%b expected %b/%b/%b",
                 col_o, key_valid_o, overrun_o, exp_col(), m_valid, m_overrun);
      end
    end
    tests_run++;
    if (col_o !== 4'b0111) begin tests_failed++; $display("[TB] FAIL bounce_col got %b expected 0111", col_o); end
    tests_run++;
    if (key_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL bounce_valid got %b expected 0", key_valid_o); end
  endtask

  task automatic test_overrun();
    int ovr_count;
    ovr_count = 0;
    wait_for_idle_col(0);
    k_down = 1'b1; k_row = 0; k_col = 0;
    for (int i = 0; i < 12; i++) begin step(); if (overrun_o === 1'b1) ovr_count++; end
    tests_run++;
    if (key_o !== 4'h1) begin tests_failed++; $display("[TB] FAIL overrun_first_key got %h expected 1", key_o); end
    k_down = 1'b0;
    for (int i = 0; i < 12; i++) begin step(); if (overrun_o === 1'b1) ovr_count++; end
    wait_for_idle_col(3);
    k_down = 1'b1; k_row = 3; k_col = 3;
    for (int i = 0; i < 12; i++) begin
      step();
      if (overrun_o === 1'b1) ovr_count++;
      tests_run++;
      if ({col_o, key_o, key_valid_o, overrun_o} !== {exp_col(), m_key, m_valid, m_overrun}) begin
        tests_failed++;
        $display("[TB] FAIL overrun_cycle got col/key/v/ovr %b/%h/%b/%b expected %b/%h/%b/%b",
                 col_o, key_o, key_valid_o, overrun_o, exp_col(), m_key, m_valid, m_overrun);
      end
    end
    tests_run++;
    if (key_o !== 4'hD) begin tests_failed++; $display("[TB] FAIL overrun_key got %h expected d", key_o); end
    tests_run++;
    if (key_valid_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL overrun_valid got %b expected 1", key_valid_o); end
    tests_run++;
    if (ovr_count != 1) begin tests_failed++; $display("[TB] FAIL overrun_pulses got %0d expected 1", ovr_count); end
  endtask

  task automatic test_same_cycle_ack();
    k_down = 1'b0;
    for (int i = 0; i < 12; i++) step();
    wait_for_idle_col(1);
    k_down = 1'b1; k_row = 1; k_col = 1;
    for (int i = 0; i < 7; i++) step();
    key_ack_i = 1'b1;
    step();
    key_ack_i = 1'b0;
    tests_run++;
    if ({key_o, key_valid_o, overrun_o} !== {4'h5, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL same_cycle_ack got key/v/ovr %h/%b/%b expected 5/1/0", key_o, key_valid_o, overrun_o);
    end
    tests_run++;
    if ({col_o, key_o, key_valid_o, overrun_o} !== {exp_col(), m_key, m_valid, m_overrun}) begin
      tests_failed++;
      $display("[TB] FAIL same_cycle_model got col/key/v/ovr %b/%h/%b/%b expected %b/%h/%b/%b",
               col_o, key_o, key_valid_o, overrun_o, exp_col(), m_key, m_valid, m_overrun);
    end
  endtask

  task automatic test_reset_held();
    int valid_seen;
    valid_seen = 0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    step();
    tests_run++;
    if ({col_o, key_o, key_valid_o, overrun_o} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_held got col/key/v/ovr %b/%h/%b/%b expected 1110/0/0/0",
               col_o, key_o, key_valid_o, overrun_o);
    end
    k_down = 1'b0;
    rst_n  = 1'b1;
    for (int i = 0; i < 48; i++) begin
      step();
      if (key_valid_o !== 1'b0) valid_seen++;
      tests_run++;
      if (col_o !== exp_col()) begin
        tests_failed++;
        $display("[TB] FAIL reset_held_scan got col %b expected %b", col_o, exp_col());
      end
    end
    tests_run++;
    if (valid_seen != 0) begin tests_failed++; $display("[TB] FAIL reset_held_no_key valid seen %0d cycles expected 0", valid_seen); end
  endtask

  task automatic test_random();
    int hold_left;
    hold_left = 0;
    for (int t = 0; t < 150; t++) begin
      if (k_down) begin
        if (hold_left == 0) k_down = 1'b0;
        else hold_left--;
      end else if ($urandom_range(0, 2) == 0) begin
        k_row     = int'($urandom_range(0, 3));
        k_col     = int'($urandom_range(0, 3));
        k_down    = 1'b1;
        hold_left = int'($urandom_range(0, 6));
      end
      for (int c = 0; c < SCAN_DIV; c++) begin
        key_ack_i = ($urandom_range(0, 5) == 0);
        step();
        tests_run++;
        if ({col_o, key_o, key_valid_o, overrun_o} !== {exp_col(), m_key, m_valid, m_overrun}) begin
          tests_failed++;
          $display("[TB] FAIL random tick %0d got col/key/v/ovr %b/%h/%b/%b expected %b/%h/%b/%b",
                   t, col_o, key_o, key_valid_o, overrun_o, exp_col(), m_key, m_valid, m_overrun);
        end
      end
    end
    key_ack_i = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle();
    test_press_key6();
    test_bounce();
    test_overrun();
    test_same_cycle_ack();
    test_reset_held();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, meaning clk cycles per column dwell (minimum 2).
REQ-002 SHALL have parameter DB_COUNT, default 4, meaning consecutive matching dwell ticks needed to accept a press or release (minimum 1).
REQ-003 SHALL have port clk  input  1  system clock, all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port row_i  input  4  keypad rows, active-low, asynchronous to clk, pulled up externally.
REQ-006 SHALL have port col_o  output  4  column drive, exactly one bit low at all times.
REQ-007 SHALL have port key_o  output  4  hex code of last accepted key.
REQ-008 SHALL have port key_valid_o  output  1  key_o holds an unacknowledged key.
REQ-009 SHALL have port key_ack_i  input  1  consumer acknowledge, one cycle pulse or level.
REQ-010 SHALL have port overrun_o  output  1  one-cycle pulse, key accepted while previous still unacknowledged.

Function
REQ-011 SHALL pass row_i through a 2-flop synchronizer; all decisions use the synchronized value (rs).
REQ-012 SHALL generate tick once every SCAN_DIV cycles from a free-running counter wrapping SCAN_DIV-1 -> 0.
REQ-013 SHALL implement FSM states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-014 SCAN: on tick with rs == 4'b1111, col_o SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110.
REQ-015 SCAN: on tick with rs != 4'b1111, SHALL latch column index and lowest-index low row, freeze col_o, enter DEBOUNCE with count = 1.
REQ-016 DEBOUNCE: on tick with latched row still low, count SHALL increment; on tick with it high, SHALL return to SCAN and advance col_o.
REQ-017 DEBOUNCE: when count reaches DB_COUNT (DB_COUNT = 1: immediately at detection tick), SHALL load key_o, set key_valid_o, enter HELD; outputs visible the cycle after the accepting tick.
REQ-018 HELD: col_o frozen; on tick with rs == 4'b1111 SHALL enter RELEASE with count = 1.
REQ-019 RELEASE: tick with rs == 4'b1111 increments count, at DB_COUNT SHALL enter SCAN and advance col_o; tick with any row low SHALL return to HELD without a new key.
REQ-020 Encoding (row r, column c) SHALL be: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E,0,F,D (E = *, F = #).
REQ-021 key_valid_o SHALL clear the cycle after key_ack_i high while set; ack while clear SHALL be ignored.
REQ-022 Accept with key_valid_o already set and no ack in that cycle SHALL overwrite key_o, keep key_valid_o = 1, pulse overrun_o one cycle.
REQ-023 Accept and key_ack_i in the same cycle SHALL leave key_valid_o = 1 with the new key and no overrun_o.
REQ-024 key_o SHALL hold its value after ack until the next accept.

Reset
REQ-025 With rst_n low at posedge clk SHALL set: col_o = 1110, key_o = 0, key_valid_o = 0, overrun_o = 0, state SCAN, tick and debounce counters 0, synchronizer flops 1111.
REQ-026 Reset asserted in any state, mid-debounce included, SHALL take effect the next edge; no key SHALL be emitted from a partially debounced press.

Structure
REQ-027 Package keypad_pkg SHALL hold the state enum, the 16-entry key table constant, and default SCAN_DIV/DB_COUNT.
REQ-028 Sub-module keypad_tick_gen SHALL implement the SCAN_DIV divider and tick output; the rest stays in keypad_scanner.

Verification (SCAN_DIV = 4, DB_COUNT = 2)
REQ-029 Reset: rst_n low 3 cycles -> col_o = 1110, key_o = 0, key_valid_o = 0, overrun_o = 0.
REQ-030 Idle: row_i = 1111 -> col_o steps 1110, 1101, 1011, 0111, 1110, each held 4 cycles.
REQ-031 Press row1/col2 (low while col_o = 1011) held 3 ticks -> key_o = 6, key_valid_o = 1, col_o stays 1011; ack -> valid 0 next cycle.
REQ-032 Bounce: row low for detection tick only, high next tick -> no key_valid_o, col_o resumes at 0111.
REQ-033 Two presses (key 1 then key D), no ack -> key_o = D, key_valid_o = 1, overrun_o pulses exactly once.
REQ-034 rst_n low during HELD with key pressed -> reset values next cycle; released key after reset produces no key.
